// File: rtl/dsp_reset_responder.sv
// Device-side Sound Blaster DSP reset responder: decodes host I/O cycles, times the
// reset pulse and startup delay, then presents 0xAA for the host to read.
module dsp_reset_responder #(
  parameter logic [15:0] BASE_ADDR         = 16'h0220,
  parameter logic [15:0] RESET_HOLD_CYCLES = 16'd150,
  parameter logic [15:0] RESPONSE_DELAY    = 16'd5000
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        iow_n,
  input  logic        ior_n,
  output logic [15:0] data_out,
  output logic        data_dir,
  output logic        data_avail,
  output logic        handshake_done
);

  localparam logic [15:0] ADDR_RST   = BASE_ADDR + 16'h0006;
  localparam logic [15:0] ADDR_DATA  = BASE_ADDR + 16'h000A;
  localparam logic [15:0] ADDR_WSTAT = BASE_ADDR + 16'h000C;
  localparam logic [15:0] ADDR_RSTAT = BASE_ADDR + 16'h000E;
  localparam logic [15:0] HOLD_LAST  = RESET_HOLD_CYCLES - 16'd1;
  localparam logic [15:0] DELAY_LAST = RESPONSE_DELAY - 16'd1;

  typedef enum logic [1:0] {IDLE, RST_HIGH, DELAY, READY} state_t;

  state_t      state, state_nxt;
  logic [15:0] count, count_nxt, count_inc;
  logic [7:0]  latch, latch_nxt;
  logic        iow_d, ior_d;
  logic        rd_is_data, rd_is_data_nxt;
  logic [15:0] data_out_nxt;
  logic        data_dir_nxt, data_avail_nxt, handshake_done_nxt;

  logic write_ev, read_start, read_end;
  logic rst_set, rst_clr, data_end, rd_match;
  logic [15:0] rd_value;
  logic unused_data;

  assign unused_data = ^data_in[15:1];

  // Strobe edge events; a write in the same cycle suppresses a read start
  assign write_ev   = !iow_n && iow_d;
  assign read_start = !ior_n && ior_d && !write_ev;
  assign read_end   = ior_n && !ior_d;
  assign rst_set    = write_ev && (address == ADDR_RST) && data_in[0];
  assign rst_clr    = write_ev && (address == ADDR_RST) && !data_in[0];
  assign data_end   = read_end && rd_is_data;
  assign count_inc  = (count == 16'hFFFF) ? count : count + 16'd1;

  // State register and all registered outputs
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 16'd0;
      latch          <= 8'h00;
      iow_d          <= 1'b1;
      ior_d          <= 1'b1;
      rd_is_data     <= 1'b0;
      data_out       <= 16'h0000;
      data_dir       <= 1'b0;
      data_avail     <= 1'b0;
      handshake_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      latch          <= latch_nxt;
      iow_d          <= iow_n;
      ior_d          <= ior_n;
      rd_is_data     <= rd_is_data_nxt;
      data_out       <= data_out_nxt;
      data_dir       <= data_dir_nxt;
      data_avail     <= data_avail_nxt;
      handshake_done <= handshake_done_nxt;
    end
  end

  // Next-state and counter
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (rst_set) begin
          state_nxt = RST_HIGH;
          count_nxt = 16'd0;
        end
      end
      RST_HIGH: begin
        count_nxt = count_inc;
        if (rst_set) begin
          count_nxt = 16'd0;
        end else if (rst_clr) begin
          count_nxt = 16'd0;
          state_nxt = (count >= HOLD_LAST) ? DELAY : IDLE;
        end
      end
      DELAY: begin
        count_nxt = count_inc;
        if (rst_set) begin
          state_nxt = RST_HIGH;
          count_nxt = 16'd0;
        end else if (count == DELAY_LAST) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (rst_set) begin
          state_nxt = RST_HIGH;
          count_nxt = 16'd0;
        end else if (data_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 16'd0;
      end
    endcase
  end

  // Read-data selection at read start
  always_comb begin
    rd_match = 1'b1;
    rd_value = 16'h0000;
    case (address)
      ADDR_DATA:  rd_value = {8'h00, latch};
      ADDR_WSTAT: rd_value = ((state == RST_HIGH) || (state == DELAY)) ? 16'h0080 : 16'h0000;
      ADDR_RSTAT: rd_value = {8'h00, data_avail, 7'b0};
      default:    rd_match = 1'b0;
    endcase
  end

  // Output next values
  always_comb begin
    latch_nxt          = latch;
    data_out_nxt       = data_out;
    data_dir_nxt       = data_dir;
    rd_is_data_nxt     = rd_is_data;
    data_avail_nxt     = (state_nxt == READY);
    handshake_done_nxt = (state == READY) && (state_nxt == IDLE);
    if ((state == DELAY) && (state_nxt == READY)) begin
      latch_nxt = 8'hAA;
    end
    if (read_start && rd_match) begin
      data_out_nxt   = rd_value;
      data_dir_nxt   = 1'b1;
      rd_is_data_nxt = (address == ADDR_DATA);
    end else if (read_end) begin
      data_dir_nxt   = 1'b0;
      rd_is_data_nxt = 1'b0;
    end
  end

endmodule
